// File: rtl/fmap_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fmap_mem_pkg
// Purpose  : Shared types and helpers for the banked feature-map buffer.
//            - state_e      : clear-sequencer states
//            - rd_lat_legal : read-latency legality check
//            - ch_lsb       : bit offset of channel c in a packed bus
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fmap_mem_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int c_RD_LAT_MIN = 1;
    localparam int c_RD_LAT_MAX = 2;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= c_RD_LAT_MIN) && (lat <= c_RD_LAT_MAX);
    endfunction

    // Channel c occupies bits [c*w +: w] of every packed data bus.
    function automatic int ch_lsb(input int c, input int w);
        return c * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fmap_mem_banked_if.sv
`default_nettype none
// ============================================================================
// Module   : fmap_mem_banked_if
// Purpose  : Access bus of the banked feature-map buffer.
// Ports    : master drives clr, ena, wea, addra, dina, enb, addrb;
//            slave (the memory) drives busy, doutb, doutb_valid.
// Revision : 1.0 - initial release
// ============================================================================
interface fmap_mem_banked_if #(
    parameter int In_W       = 32,
    parameter int In_D_Add_W = 4,
    parameter int CH         = 4
) ();
    logic                    clr;
    logic                    busy;
    logic                    ena;
    logic [CH-1:0]           wea;
    logic [In_D_Add_W-1:0]   addra;
    logic [CH*In_W-1:0]      dina;
    logic                    enb;
    logic [In_D_Add_W-1:0]   addrb;
    logic [CH*In_W-1:0]      doutb;
    logic                    doutb_valid;

    modport master (
        output clr, ena, wea, addra, dina, enb, addrb,
        input  busy, doutb, doutb_valid
    );

    modport slave (
        input  clr, ena, wea, addra, dina, enb, addrb,
        output busy, doutb, doutb_valid
    );
endinterface
`default_nettype wire

// File: rtl/fmap_bank.sv
`default_nettype none
// ============================================================================
// Module   : fmap_bank
// Purpose  : One In_W x 2**In_D_Add_W memory bank with a write port, a
//            write-first read port and a single read register.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            we_i, waddr_i, wdata_i - write port
//            re_i, raddr_i - read request
//            rdata_o       - registered read data (holds when re_i=0)
// Revision : 1.0 - initial release
// ============================================================================
module fmap_bank #(
    parameter int In_W       = 32,
    parameter int In_D_Add_W = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  we_i,
    input  wire logic [In_D_Add_W-1:0] waddr_i,
    input  wire logic [In_W-1:0]       wdata_i,
    input  wire logic                  re_i,
    input  wire logic [In_D_Add_W-1:0] raddr_i,
    output logic      [In_W-1:0]       rdata_o
);
    localparam int DEPTH = 2 ** In_D_Add_W;

    logic [In_W-1:0] mem_q [DEPTH];
    logic [In_W-1:0] rdata_q;

    // Array has no reset; the clear sequencer in the top initialises it.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-address write in the same cycle is forwarded (write-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule
`default_nettype wire

// File: rtl/fmap_mem_banked.sv
`default_nettype none
// ============================================================================
// Module   : fmap_mem_banked
// Purpose  : CH-bank single-clock feature-map buffer with per-channel write
//            mask, concurrent write-first read, RD_LAT of 1 or 2 and a
//            hardware clear sequencer run after reset or on clr.
// Ports    : clk  - clock
//            rst  - synchronous active-high reset (enters clear)
//            bus  - fmap_mem_banked_if.slave (clr/busy, write port a,
//                   read port b, doutb/doutb_valid)
// Revision : 1.0 - initial release
// ============================================================================
module fmap_mem_banked
    import fmap_mem_pkg::*;
#(
    parameter int In_W       = 32,
    parameter int In_D_Add_W = 4,
    parameter int CH         = 4,
    parameter int RD_LAT     = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fmap_mem_banked_if.slave bus
);
    localparam int                    DEPTH       = 2 ** In_D_Add_W;
    localparam logic [In_D_Add_W-1:0] c_LAST_ADDR = In_D_Add_W'(DEPTH - 1);

    generate
        if (!rd_lat_legal(RD_LAT)) begin : g_bad_lat
            $error("fmap_mem_banked: RD_LAT must be 1 or 2");
        end
    endgenerate

    state_e                  state_q, state_d;
    logic [In_D_Add_W-1:0]   clr_cnt_q, clr_cnt_d;

    logic                    busy_w;
    logic                    run_acc_w;
    logic [CH-1:0]           bank_we_w;
    logic [In_D_Add_W-1:0]   waddr_w;
    logic [CH*In_W-1:0]      wdata_w;
    logic                    re_w;
    logic [CH*In_W-1:0]      rd_w;
    logic                    rd_vld_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state logic. The counter rests at 0 in RUN so that a clr request
    // always restarts the sweep from address 0.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == c_LAST_ADDR) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                clr_cnt_d = '0;
                if (bus.clr) begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Output logic: during CLEAR the write port is taken over to write zeros;
    // in RUN a clr request drops any access of the same cycle.
    always_comb begin
        busy_w    = (state_q == ST_CLEAR);
        run_acc_w = (state_q == ST_RUN) && !bus.clr;
        bank_we_w = busy_w ? {CH{1'b1}} : ({CH{run_acc_w & bus.ena}} & bus.wea);
        waddr_w   = busy_w ? clr_cnt_q : bus.addra;
        wdata_w   = busy_w ? '0 : bus.dina;
        re_w      = run_acc_w && bus.enb;
    end

    generate
        for (genvar c = 0; c < CH; c++) begin : g_bank
            fmap_bank #(
                .In_W       (In_W),
                .In_D_Add_W (In_D_Add_W)
            ) u_bank (
                .clk     (clk),
                .rst     (rst),
                .we_i    (bank_we_w[c]),
                .waddr_i (waddr_w),
                .wdata_i (wdata_w[ch_lsb(c, In_W) +: In_W]),
                .re_i    (re_w),
                .raddr_i (bus.addrb),
                .rdata_o (rd_w[ch_lsb(c, In_W) +: In_W])
            );
        end
    endgenerate

    // Valid tracks the bank read register; not gated by clr so that reads
    // already accepted still complete during a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= re_w;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [CH*In_W-1:0] dout_q;
            logic               dout_vld_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q     <= '0;
                    dout_vld_q <= 1'b0;
                end else begin
                    dout_vld_q <= rd_vld_q;
                    if (rd_vld_q) begin
                        dout_q <= rd_w;
                    end
                end
            end

            assign bus.doutb       = dout_q;
            assign bus.doutb_valid = dout_vld_q;
        end else begin : g_lat1
            assign bus.doutb       = rd_w;
            assign bus.doutb_valid = rd_vld_q;
        end
    endgenerate

    assign bus.busy = busy_w;
endmodule
`default_nettype wire

// File: tb/tb_fmap_mem_banked.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmap_mem_banked
// Purpose  : Self-checking bench; drives one RD_LAT=1 and one RD_LAT=2
//            instance with identical stimulus and scoreboards both.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fmap_mem_banked;
    localparam int W     = 32;
    localparam int AW    = 4;
    localparam int CH    = 4;
    localparam int DEPTH = 16;
    localparam int DW    = CH * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fmap_mem_banked_if #(.In_W(W), .In_D_Add_W(AW), .CH(CH)) bus1 ();
    fmap_mem_banked_if #(.In_W(W), .In_D_Add_W(AW), .CH(CH)) bus2 ();

    fmap_mem_banked #(.In_W(W), .In_D_Add_W(AW), .CH(CH), .RD_LAT(1)) u_dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );
    fmap_mem_banked #(.In_W(W), .In_D_Add_W(AW), .CH(CH), .RD_LAT(2)) u_dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          q1[$];
    exp_t          q2[$];
    exp_t          e1, e2;
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic          rst_q    = 1'b0;
    logic          running  = 1'b0;
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] last1    = '0;
    logic [DW-1:0] last2    = '0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Scoreboard monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_q) begin
            last1 = '0;
            q1.delete();
        end
        if (bus1.doutb_valid) begin
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL lat1_spurious cyc=%0d got valid doutb=%h, required no valid", cyc, bus1.doutb);
            end else begin
                e1 = q1.pop_front();
                if (e1.due !== cyc || bus1.doutb !== e1.data) begin
                    failures++;
                    $display("FAIL lat1_data cyc=%0d got=%h required=%h at cyc=%0d", cyc, bus1.doutb, e1.data, e1.due);
                end
            end
            last1 = bus1.doutb;
        end else begin
            checks++;
            if (bus1.doutb !== last1) begin
                failures++;
                $display("FAIL lat1_hold cyc=%0d got=%h required=%h", cyc, bus1.doutb, last1);
            end
            if (q1.size() > 0 && q1[0].due <= cyc) begin
                checks++;
                failures++;
                $display("FAIL lat1_missing cyc=%0d got no valid, required=%h", cyc, q1[0].data);
                void'(q1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_q) begin
            last2 = '0;
            q2.delete();
        end
        if (bus2.doutb_valid) begin
            checks++;
            if (q2.size() == 0) begin
                failures++;
                $display("FAIL lat2_spurious cyc=%0d got valid doutb=%h, required no valid", cyc, bus2.doutb);
            end else begin
                e2 = q2.pop_front();
                if (e2.due !== cyc || bus2.doutb !== e2.data) begin
                    failures++;
                    $display("FAIL lat2_data cyc=%0d got=%h required=%h at cyc=%0d", cyc, bus2.doutb, e2.data, e2.due);
                end
            end
            last2 = bus2.doutb;
        end else begin
            checks++;
            if (bus2.doutb !== last2) begin
                failures++;
                $display("FAIL lat2_hold cyc=%0d got=%h required=%h", cyc, bus2.doutb, last2);
            end
            if (q2.size() > 0 && q2[0].due <= cyc) begin
                checks++;
                failures++;
                $display("FAIL lat2_missing cyc=%0d got no valid, required=%h", cyc, q2[0].data);
                void'(q2.pop_front());
            end
        end
    end

    // One bus cycle on both instances; model and scoreboard updated here.
    task automatic drive(input logic c, input logic e, input logic [CH-1:0] we,
                         input logic [AW-1:0] aa, input logic [DW-1:0] di,
                         input logic eb, input logic [AW-1:0] ab);
        logic [DW-1:0] ex;
        bus1.clr = c;  bus1.ena = e;  bus1.wea = we; bus1.addra = aa;
        bus1.dina = di; bus1.enb = eb; bus1.addrb = ab;
        bus2.clr = c;  bus2.ena = e;  bus2.wea = we; bus2.addra = aa;
        bus2.dina = di; bus2.enb = eb; bus2.addrb = ab;
        if (running && !rst && !c) begin
            if (eb) begin
                for (int ch = 0; ch < CH; ch++) begin
                    ex[ch*W +: W] = (e && we[ch] && aa == ab) ? di[ch*W +: W] : mem_m[ab][ch*W +: W];
                end
                q1.push_back('{data: ex, due: cyc + 1});
                q2.push_back('{data: ex, due: cyc + 2});
            end
            if (e) begin
                for (int ch = 0; ch < CH; ch++) begin
                    if (we[ch]) mem_m[aa][ch*W +: W] = di[ch*W +: W];
                end
            end
        end
        if (c || rst) begin
            running = 1'b0;
            for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    // Counts busy cycles from now; returns at the first falling edge with
    // both instances idle so the next drive lands in the first RUN cycle.
    task automatic busy_len(output int n1, output int n2);
        n1 = 0;
        n2 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus1.busy) n1++;
            if (bus2.busy) n2++;
            if (!bus1.busy && !bus2.busy) break;
        end
        running = 1'b1;
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) drive(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(a));
        idle(); idle(); idle();
    endtask

    task automatic test_reset();
        int n1, n2;
        rst = 1'b1;
        idle();
        rst = 1'b0;
        checks++;
        if (bus1.doutb !== '0 || bus1.doutb_valid !== 1'b0 || bus1.busy !== 1'b1 ||
            bus2.doutb !== '0 || bus2.doutb_valid !== 1'b0 || bus2.busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_values got d1=%h v1=%b b1=%b d2=%h v2=%b b2=%b, required 0/0/1",
                     bus1.doutb, bus1.doutb_valid, bus1.busy, bus2.doutb, bus2.doutb_valid, bus2.busy);
        end
        busy_len(n1, n2);
        checks++;
        if (n1 != 16 || n2 != 16) begin
            failures++;
            $display("FAIL reset_busy_len got %0d/%0d, required 16", n1, n2);
        end
        read_all();
    endtask

    task automatic test_write_mask();
        logic [DW-1:0] want;
        want = {32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF8, 32'd0};
        drive(1'b0, 1'b1, 4'b1010, 4'd5, {32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF8, 32'd2}, 1'b0, '0);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd5);
        @(negedge clk);
        checks++;
        if (bus1.doutb !== want || bus1.doutb_valid !== 1'b1) begin
            failures++;
            $display("FAIL mask_lat1 got=%h v=%b, required=%h v=1", bus1.doutb, bus1.doutb_valid, want);
        end
        idle();
        @(negedge clk);
        checks++;
        if (bus2.doutb !== want || bus2.doutb_valid !== 1'b1) begin
            failures++;
            $display("FAIL mask_lat2 got=%h v=%b, required=%h v=1", bus2.doutb, bus2.doutb_valid, want);
        end
        idle(); idle();
    endtask

    task automatic test_collision();
        logic [DW-1:0] want;
        want = {32'h11, 32'h11, 32'h11, 32'h55};
        drive(1'b0, 1'b1, 4'b1111, 4'd3, {4{32'h11}}, 1'b0, '0);
        drive(1'b0, 1'b1, 4'b0001, 4'd3, {4{32'h55}}, 1'b1, 4'd3);
        @(negedge clk);
        checks++;
        if (bus1.doutb !== want) begin
            failures++;
            $display("FAIL collision_lat1 got=%h required=%h", bus1.doutb, want);
        end
        idle(); idle(); idle();
    endtask

    task automatic test_back_to_back();
        // Writes with a concurrent read of a different address each cycle.
        for (int a = 0; a < DEPTH; a++) begin
            drive(1'b0, 1'b1, 4'b1111, AW'(a), {4{32'(a)}}, 1'b1, AW'(a + 7));
        end
        read_all();
    endtask

    task automatic test_clear();
        int n1, n2;
        drive(1'b0, 1'b1, 4'b1111, 4'd2, {4{32'hA5A5_0002}}, 1'b0, '0);
        // Read accepted in the cycle before clr must still complete.
        drive(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd2);
        drive(1'b1, 1'b1, 4'b1111, 4'd9, {4{32'hDEAD_BEEF}}, 1'b1, 4'd9);
        busy_len(n1, n2);
        checks++;
        if (n1 != 16 || n2 != 16) begin
            failures++;
            $display("FAIL clr_busy_len got %0d/%0d, required 16", n1, n2);
        end
        read_all();
    endtask

    task automatic test_rst_mid_clear();
        int n1, n2;
        for (int a = 12; a < DEPTH; a++) begin
            drive(1'b0, 1'b1, 4'b1111, AW'(a), {4{32'h7700 + 32'(a)}}, 1'b0, '0);
        end
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        repeat (8) idle();
        rst = 1'b1;
        idle();
        rst = 1'b0;
        busy_len(n1, n2);
        checks++;
        if (n1 != 16 || n2 != 16) begin
            failures++;
            $display("FAIL rst_mid_clear_busy_len got %0d/%0d, required 16", n1, n2);
        end
        read_all();
    endtask

    initial begin
        test_reset();
        test_write_mask();
        test_collision();
        test_back_to_back();
        test_clear();
        test_rst_mid_clear();
        idle(); idle(); idle();
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d/%0d outstanding reads, required 0", q1.size(), q2.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fmap_mem_banked.md
# fmap_mem_banked

Multi-channel, single-clock feature-map buffer for the classification accelerator. It supersedes the single-channel dual-clock memory with CH parallel banks sharing one address space. It adds a per-channel write mask, concurrent read and write with write-first collision bypass, and a selectable read latency (1 or 2). A hardware clear sequencer zeroes the whole array after reset or on request.

## Interface
- In_W, 32, signed word width per channel
- In_D_Add_W, 4, address width; depth = 2**In_D_Add_W
- CH, 4, number of channels (banks), ≥1
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- clr  input  1  request full-array clear (sampled only when busy=0)
- busy  output  1  clear sequence in progress; all accesses ignored
- ena  input  1  write port enable
- wea  input  CH  per-channel write mask
- addra  input  In_D_Add_W  write address
- dina  input  CH*In_W  write data, channel c at bits [c*In_W +: In_W], signed
- enb  input  1  read port enable
- addrb  input  In_D_Add_W  read address
- doutb  output  CH*In_W  read data, same packing as dina
- doutb_valid  output  1  doutb holds the result of an accepted read

## Operation
- States: CLEAR, RUN. rst (any state, including mid-clear) → CLEAR with clear counter = 0.
- CLEAR: each cycle writes 0 to address counter in all channels, counter += 1. After address depth-1 is written → RUN. Takes exactly depth cycles. ena, enb, clr ignored; no doutb_valid pulses.
- RUN, clr=1: → CLEAR next cycle. ena/enb in the same cycle are dropped (clr has priority).
- RUN write: ena=1 → for each c with wea[c]=1, bank c[addra] ← dina channel c. Channels with wea[c]=0 are unchanged. ena=1 with wea=0 is a no-op.
- RUN read: enb=1 → read addrb in all channels. Reads and writes are fully concurrent; there is no wea/enb exclusion.
- Collision (ena=1, enb=1, addra==addrb, same cycle): write-first. Channels with wea[c]=1 return the new dina; the others return the stored value.
- doutb holds its last value when no read completes. doutb_valid pulses 1 cycle per accepted read.
- Pipeline stages are not flushed by clr. A read accepted in the cycle before clr still completes. After rst, the pipeline is cleared.
- Reset values: doutb=0, doutb_valid=0, busy=1 (CLEAR entered), clear counter=0. Memory contents are undefined until the clear completes.

## Timing
- busy=1 from the first cycle after rst/clr is sampled through the last clear write. busy=0 in the cycle after the final write; the first access is accepted in that cycle.
- RD_LAT=1: read accepted at edge k → doutb/doutb_valid updated at edge k (visible in cycle k+1).
- RD_LAT=2: one extra output register; result visible in cycle k+2. A write at edge k+1 to the same address does not alter the in-flight data.
- Full throughput: one read and one write per cycle, back-to-back, any addresses.
- Address wrap: addresses are modulo depth by width. The clear counter stops at depth-1 and does not wrap into RUN data.

## Structure
- Package fmap_mem_pkg holds:
  - the state enum (CLEAR, RUN)
  - the RD_LAT legality check constant
  - the channel-slice helper function
- Sub-module fmap_bank: one In_W × depth bank with write enable, write-first read, and a single read register. It is instantiated CH times.
- Top level holds the clear FSM, clear mux on the write port, valid pipeline, and optional second output stage.

## Test plan
- Reset, then hold: busy=1 for exactly 16 cycles (In_D_Add_W=4). Then read all addresses → every channel reads 0, one doutb_valid per read.
- RUN, write addr 5, wea=4'b1010, dina channels {3:0}={-1, 7, -8, 2}. Read addr 5 → channels {-1, 0, -8, 0}, valid at +1 cycle (RD_LAT=1) and +2 cycles (RD_LAT=2).
- Same-cycle write/read addr 3, wea=4'b0001, data 0x55 on channel 0, prior contents 0x11 in all channels. Read → ch0=0x55, ch1..3=0x11.
- Back-to-back reads addr 0..15 after writing data=address in each location → doutb sequence 0..15, doutb_valid high 16 consecutive cycles.
- clr asserted in RUN with ena=1 in the same cycle → write dropped, busy=1 for 16 cycles, all reads afterwards return 0.
- Assert rst at clear cycle 8 → busy stays 1 for a full 16 further cycles, then all locations read 0.
